// File: rtl/mac_array_stream_if.sv
// mac_array_stream_if: job control, operand stream and result stream.
// sat_flag exists only when MAC_ARRAY_SATURATE_EN is defined.
interface mac_array_stream_if #(
   parameter int LANES = 4,
   parameter int DW    = 8,
   parameter int ACCW  = 32,
   parameter int LENW  = 16
);
   logic                  start;
   logic [LENW-1:0]       cfg_len;
   logic                  in_valid;
   logic                  in_ready;
   logic [LANES*DW-1:0]   a_flat;
   logic [LANES*DW-1:0]   b_flat;
   logic                  out_valid;
   logic                  out_ready;
   logic [LANES*ACCW-1:0] out_data;
   logic                  busy;
`ifdef MAC_ARRAY_SATURATE_EN
   logic [LANES-1:0]      sat_flag;

   modport master (
      output start, cfg_len, in_valid, a_flat, b_flat, out_ready,
      input  in_ready, out_valid, out_data, busy, sat_flag
   );
   modport slave (
      input  start, cfg_len, in_valid, a_flat, b_flat, out_ready,
      output in_ready, out_valid, out_data, busy, sat_flag
   );
`else
   modport master (
      output start, cfg_len, in_valid, a_flat, b_flat, out_ready,
      input  in_ready, out_valid, out_data, busy
   );
   modport slave (
      input  start, cfg_len, in_valid, a_flat, b_flat, out_ready,
      output in_ready, out_valid, out_data, busy
   );
`endif
endinterface

// File: rtl/mac_array_stream.sv
// mac_array_stream: LANES signed dot-product lanes, multiply then accumulate.
// Define MAC_ARRAY_SATURATE_EN for clamping accumulators plus sat_flag.
module mac_array_stream #(
   parameter int LANES = 4,
   parameter int DW    = 8,
   parameter int ACCW  = 32,
   parameter int LENW  = 16
) (
   input  logic              clk,
   input  logic              rst,
   mac_array_stream_if.slave bus
);
`ifdef MAC_ARRAY_SATURATE_EN
   localparam int SW = ACCW + 1;
`else
   localparam int SW = ACCW;
`endif

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_e;

   state_e                 state_q, state_d;
   logic [LENW-1:0]        len_q, len_d;
   logic [LENW-1:0]        cnt_q, cnt_d;
   logic                   s1_vld_q, s1_vld_d;
   logic                   clr;
   logic                   xfer;
   logic signed [2*DW-1:0] prod_q [LANES];
   logic signed [2*DW-1:0] prod_d [LANES];
   logic signed [ACCW-1:0] acc_q [LANES];
   logic signed [ACCW-1:0] acc_d [LANES];
`ifdef MAC_ARRAY_SATURATE_EN
   logic [LANES-1:0]       sat_q, sat_d;
`endif

   assign xfer          = bus.in_valid && (state_q == RUN);
   assign bus.in_ready  = (state_q == RUN);
   assign bus.out_valid = (state_q == HOLD);
   assign bus.busy      = (state_q != IDLE);
`ifdef MAC_ARRAY_SATURATE_EN
   assign bus.sat_flag  = sat_q;
`endif

   // Job sequencing: length latch, beat counter and state transitions.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      clr     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               len_d   = bus.cfg_len;
               cnt_d   = '0;
               clr     = 1'b1;
               state_d = (bus.cfg_len == '0) ? HOLD : RUN;
            end
         end
         RUN: begin
            if (xfer) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == len_q) state_d = DRAIN;
            end
         end
         DRAIN: state_d = HOLD;
         HOLD: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Stage 1: register per-lane signed products of each accepted beat.
   always_comb begin
      logic signed [DW-1:0] a_s;
      logic signed [DW-1:0] b_s;
      a_s      = '0;
      b_s      = '0;
      s1_vld_d = xfer;
      for (int i = 0; i < LANES; i++) begin
         a_s       = bus.a_flat[i*DW +: DW];
         b_s       = bus.b_flat[i*DW +: DW];
         prod_d[i] = prod_q[i];
         if (xfer) prod_d[i] = (2*DW)'(a_s) * (2*DW)'(b_s);
      end
   end

   // Stage 2: fold the registered products into the lane accumulators.
   always_comb begin
      logic signed [SW-1:0] sum;
      sum = '0;
`ifdef MAC_ARRAY_SATURATE_EN
      sat_d = clr ? '0 : sat_q;
`endif
      for (int i = 0; i < LANES; i++) begin
         sum      = SW'(acc_q[i]) + SW'(prod_q[i]);
         acc_d[i] = acc_q[i];
         if (clr) begin
            acc_d[i] = '0;
         end else if (s1_vld_q) begin
`ifdef MAC_ARRAY_SATURATE_EN
            if (sum[SW-1] != sum[SW-2]) begin
               acc_d[i] = sum[SW-1] ? {1'b1, {(ACCW-1){1'b0}}}
                                    : {1'b0, {(ACCW-1){1'b1}}};
               sat_d[i] = 1'b1;
            end else begin
               acc_d[i] = sum[ACCW-1:0];
            end
`else
            acc_d[i] = sum;
`endif
         end
      end
   end

   // Result bus mirrors the accumulators; they hold after the handoff.
   always_comb begin
      bus.out_data = '0;
      for (int i = 0; i < LANES; i++) begin
         bus.out_data[i*ACCW +: ACCW] = acc_q[i];
      end
   end

   // State and datapath registers; reset aborts any job in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         len_q    <= '0;
         cnt_q    <= '0;
         s1_vld_q <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            prod_q[i] <= '0;
            acc_q[i]  <= '0;
         end
`ifdef MAC_ARRAY_SATURATE_EN
         sat_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         s1_vld_q <= s1_vld_d;
         for (int i = 0; i < LANES; i++) begin
            prod_q[i] <= prod_d[i];
            acc_q[i]  <= acc_d[i];
         end
`ifdef MAC_ARRAY_SATURATE_EN
         sat_q <= sat_d;
`endif
      end
   end
endmodule

// File: tb/tb_mac_array_stream.sv
// tb_mac_array_stream: ACCW=32 and ACCW=16 instances share one stimulus.
// Expected sums come from a per-beat arithmetic model of the job queue.
module tb_mac_array_stream;
   localparam int LANES = 4;
   localparam int DW    = 8;
   localparam int LENW  = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [31:0]  qa [$];
   logic [31:0]  qb [$];
   logic [127:0] e32;
   logic [63:0]  e16;
   logic [3:0]   s32;
   logic [3:0]   s16;

   always #5 clk = ~clk;

   mac_array_stream_if #(.LANES(LANES), .DW(DW), .ACCW(32), .LENW(LENW)) ifa ();
   mac_array_stream_if #(.LANES(LANES), .DW(DW), .ACCW(16), .LENW(LENW)) ifb ();

   assign ifb.start     = ifa.start;
   assign ifb.cfg_len   = ifa.cfg_len;
   assign ifb.in_valid  = ifa.in_valid;
   assign ifb.a_flat    = ifa.a_flat;
   assign ifb.b_flat    = ifa.b_flat;
   assign ifb.out_ready = ifa.out_ready;

   mac_array_stream #(.LANES(LANES), .DW(DW), .ACCW(32), .LENW(LENW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   mac_array_stream #(.LANES(LANES), .DW(DW), .ACCW(16), .LENW(LENW)) dut16 (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One accumulate step of a w-bit lane, wrapping or clamping.
   function automatic longint step(input longint v, input longint p,
                                   input int w, inout bit f);
      longint hi;
      longint lo;
      longint s;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -hi - 1;
      s  = v + p;
`ifdef MAC_ARRAY_SATURATE_EN
      if (s > hi) begin
         s = hi;
         f = 1'b1;
      end else if (s < lo) begin
         s = lo;
         f = 1'b1;
      end
`else
      while (s > hi) s -= 2 * (hi + 1);
      while (s < lo) s += 2 * (hi + 1);
`endif
      return s;
   endfunction

   function automatic void model();
      for (int l = 0; l < LANES; l++) begin
         longint x32;
         longint x16;
         bit     f32;
         bit     f16;
         logic signed [7:0] av;
         logic signed [7:0] bv;
         x32 = 0;
         x16 = 0;
         f32 = 1'b0;
         f16 = 1'b0;
         foreach (qa[k]) begin
            av  = qa[k][l*8 +: 8];
            bv  = qb[k][l*8 +: 8];
            x32 = step(x32, longint'(av) * longint'(bv), 32, f32);
            x16 = step(x16, longint'(av) * longint'(bv), 16, f16);
         end
         e32[l*32 +: 32] = x32[31:0];
         e16[l*16 +: 16] = x16[15:0];
         s32[l] = f32;
         s16[l] = f16;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int len);
      qa.delete();
      qb.delete();
      ifa.cfg_len = LENW'(len);
      ifa.start   = 1'b1;
      tick();
      ifa.start   = 1'b0;
   endtask

   // gap: 0 none, 1 alternate 1,0,1,0..., 2 random
   task automatic feed(input int n, input int gap, input bit fixed,
                       input logic [31:0] fa, input logic [31:0] fb);
      int   sent;
      int   guard;
      logic rdy;
      sent  = 0;
      guard = 0;
      while (sent < n && guard < 200) begin
         guard++;
         if ((gap == 1 && (guard % 2) == 0) ||
             (gap == 2 && $urandom_range(0, 1) == 1)) begin
            ifa.in_valid = 1'b0;
            ifa.a_flat   = $urandom;
            ifa.b_flat   = $urandom;
         end else begin
            ifa.in_valid = 1'b1;
            ifa.a_flat   = fixed ? fa : $urandom;
            ifa.b_flat   = fixed ? fb : $urandom;
         end
         @(negedge clk);
         rdy = ifa.in_ready;
         if (ifa.in_valid && rdy) begin
            qa.push_back(ifa.a_flat);
            qb.push_back(ifa.b_flat);
            sent++;
         end
         tick();
      end
      ifa.in_valid = 1'b0;
      if (sent < n) chk("feed_timeout", 128'(sent), 128'(n));
   endtask

   // Called at a negedge in HOLD: check result, stall, then hand off.
   task automatic finish_job(input int hold, input bit pulse,
                             input bit start_xfer);
      model();
      chk("data32", ifa.out_data, e32);
      chk("data16", ifb.out_data, e16);
`ifdef MAC_ARRAY_SATURATE_EN
      chk("sat32", ifa.sat_flag, s32);
      chk("sat16", ifb.sat_flag, s16);
`endif
      for (int k = 0; k < hold; k++) begin
         ifa.out_ready = 1'b0;
         ifa.cfg_len   = '0;
         ifa.start     = pulse;
         tick();
         ifa.start     = 1'b0;
         @(negedge clk);
         chk("hold_ctl", {ifa.out_valid, ifa.in_ready, ifa.busy,
                          ifb.out_valid}, 4'b1011);
         chk("hold_data", ifa.out_data, e32);
      end
      ifa.out_ready = 1'b1;
      ifa.cfg_len   = 5;
      ifa.start     = start_xfer;
      tick();
      ifa.out_ready = 1'b0;
      ifa.start     = 1'b0;
      @(negedge clk);
      chk("release", {ifa.out_valid, ifa.in_ready, ifa.busy,
                      ifb.busy}, 4'b0000);
      chk("keep32", ifa.out_data, e32);
      chk("keep16", ifb.out_data, e16);
   endtask

   task automatic run_job(input int len, input int gap, input bit fixed,
                          input logic [31:0] fa, input logic [31:0] fb,
                          input int hold, input bit pulse,
                          input bit start_xfer);
      start_job(len);
      if (len == 0) begin
         @(negedge clk);
         chk("zero_len", {ifa.out_valid, ifa.in_ready}, 2'b10);
      end else begin
         feed(len, gap, fixed, fa, fb);
         @(negedge clk);
         chk("drain", {ifa.out_valid, ifa.in_ready, ifa.busy}, 3'b001);
         @(negedge clk);
         chk("latency", {ifa.out_valid, ifb.out_valid}, 2'b11);
      end
      finish_job(hold, pulse, start_xfer);
   endtask

   initial begin
      ifa.start     = 1'b0;
      ifa.cfg_len   = '0;
      ifa.in_valid  = 1'b0;
      ifa.a_flat    = '0;
      ifa.b_flat    = '0;
      ifa.out_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_ctl", {ifa.out_valid, ifa.in_ready, ifa.busy, ifb.busy}, 4'b0);
      chk("rst_data", {ifa.out_data, ifb.out_data}, '0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // abort a 4-beat job after two beats
      start_job(4);
      feed(2, 0, 1'b1, 32'h05050505, 32'h07070707);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_ctl", {ifa.out_valid, ifa.in_ready, ifa.busy}, 3'b000);
      chk("abort_data", {ifa.out_data, ifb.out_data}, '0);
      tick();
      rst = 1'b0;
      run_job(2, 0, 1'b0, '0, '0, 0, 1'b0, 1'b0);

      // basic, then gapped with stalls and ignored starts
      run_job(3, 0, 1'b1, 32'h7F03FE01, 32'h7FFC0302, 0, 1'b0, 1'b0);
      chk("basic_lane3", ifa.out_data[127:96], 32'd48387);
      run_job(3, 1, 1'b1, 32'h7F03FE01, 32'h7FFC0302, 5, 1'b1, 1'b1);

      run_job(0, 0, 1'b0, '0, '0, 1, 1'b0, 1'b0);
      run_job(4, 0, 1'b1, 32'h80808080, 32'h80808080, 0, 1'b0, 1'b0);
      chk("neg_max", ifa.out_data[31:0], 32'd65536);
      run_job(3, 0, 1'b1, 32'h7F7F7F7F, 32'h7F7F7F7F, 1, 1'b0, 1'b0);

      for (int j = 0; j < 6; j++) begin
         run_job(int'($urandom_range(1, 8)), 2, 1'b0, '0, '0,
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
